// File: rtl/traffic_light_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | traffic_light_pkg: shared light codes, phase encoding, monitor states |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package traffic_light_pkg;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] GREEN  = 3'b010;
   localparam logic [2:0] YELLOW = 3'b001;

   localparam logic [1:0] PH_NONE   = 2'd0;
   localparam logic [1:0] PH_RED    = 2'd1;
   localparam logic [1:0] PH_GREEN  = 2'd2;
   localparam logic [1:0] PH_YELLOW = 2'd3;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } mon_state_t;

   // Next colour in the red->green->yellow->red ring; non-codes map to zero.
   function automatic logic [2:0] successor(input logic [2:0] code);
      case (code)
         RED:     successor = GREEN;
         GREEN:   successor = YELLOW;
         YELLOW:  successor = RED;
         default: successor = 3'b000;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/light_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | light_decode: one-hot light code -> {valid, phase}                    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module light_decode
   import traffic_light_pkg::*;
(
   input  logic [2:0] code,
   output logic       valid,
   output logic [1:0] phase
);

   always_comb begin
      valid = 1'b1;
      phase = PH_NONE;
      case (code)
         RED:     phase = PH_RED;
         GREEN:   phase = PH_GREEN;
         YELLOW:  phase = PH_YELLOW;
         default: valid = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | traffic_light_monitor: code/order/dwell checker for the light bus.    |
// | Optional FAULT recovery on red: TRAFFIC_LIGHT_MONITOR_RECOVER_EN.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter int MIN_DWELL = 1,
   parameter int MAX_DWELL = 1,
   parameter int CNT_W     = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [2:0]       light,
   output logic [1:0]       phase,
   output logic             in_sync,
   output logic             err_code,
   output logic             err_seq,
   output logic             err_dwell,
   output logic             fault,
   output logic [CNT_W-1:0] cycles
);

   localparam int c_DW_W = $clog2(MAX_DWELL + 1) + 1;
   localparam logic [c_DW_W-1:0] c_MIN   = c_DW_W'(MIN_DWELL);
   localparam logic [c_DW_W-1:0] c_MAX   = c_DW_W'(MAX_DWELL);
   localparam logic [c_DW_W-1:0] c_ONE   = c_DW_W'(1);
   localparam logic [CNT_W-1:0]  c_CSAT  = {CNT_W{1'b1}};

   if (MIN_DWELL < 1 || MIN_DWELL > MAX_DWELL) begin : g_param_check
      $error("traffic_light_monitor: need 1 <= MIN_DWELL <= MAX_DWELL");
   end

   mon_state_t        r_state, w_nxt_state;
   logic [2:0]        r_prev, w_nxt_prev;
   logic [c_DW_W-1:0] r_dwell, w_nxt_dwell;
   logic [1:0]        r_phase, w_nxt_phase;
   logic [CNT_W-1:0]  r_cycles, w_nxt_cycles;
   logic              r_err_code, r_err_seq, r_err_dwell;
   logic              w_err_code, w_err_seq, w_err_dwell;
   logic              w_valid;
   logic [1:0]        w_dec_phase;

   light_decode u_decode (
      .code  (light),
      .valid (w_valid),
      .phase (w_dec_phase)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_SYNC;
         r_prev      <= 3'b000;
         r_dwell     <= '0;
         r_phase     <= PH_NONE;
         r_cycles    <= '0;
         r_err_code  <= 1'b0;
         r_err_seq   <= 1'b0;
         r_err_dwell <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_prev      <= w_nxt_prev;
         r_dwell     <= w_nxt_dwell;
         r_phase     <= w_nxt_phase;
         r_cycles    <= w_nxt_cycles;
         r_err_code  <= w_err_code;
         r_err_seq   <= w_err_seq;
         r_err_dwell <= w_err_dwell;
      end
   end

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_prev   = r_prev;
      w_nxt_dwell  = r_dwell;
      w_nxt_phase  = r_phase;
      w_nxt_cycles = r_cycles;
      w_err_code   = 1'b0;
      w_err_seq    = 1'b0;
      w_err_dwell  = 1'b0;
      case (r_state)
         ST_SYNC: begin
            if (w_valid) begin
               w_nxt_prev  = light;
               w_nxt_dwell = c_ONE;
               w_nxt_phase = w_dec_phase;
               w_nxt_state = ST_TRACK;
            end
         end
         ST_TRACK: begin
            if (!w_valid) begin
               w_err_code  = 1'b1;
               w_nxt_state = ST_FAULT;
            end else if (light == r_prev) begin
               if (r_dwell == c_MAX) begin
                  w_err_dwell = 1'b1;
                  w_nxt_state = ST_FAULT;
               end else begin
                  w_nxt_dwell = r_dwell + c_ONE;
               end
            end else if (light == successor(r_prev)) begin
               if (r_dwell < c_MIN) begin
                  w_err_dwell = 1'b1;
                  w_nxt_state = ST_FAULT;
               end else begin
                  w_nxt_prev  = light;
                  w_nxt_dwell = c_ONE;
                  w_nxt_phase = w_dec_phase;
                  // A completed cycle is the yellow->red edge.
                  if (r_prev == YELLOW && r_cycles != c_CSAT)
                     w_nxt_cycles = r_cycles + CNT_W'(1);
               end
            end else begin
               w_err_seq   = 1'b1;
               w_nxt_state = ST_FAULT;
            end
         end
         ST_FAULT: begin
`ifdef TRAFFIC_LIGHT_MONITOR_RECOVER_EN
            if (light == RED) begin
               w_nxt_prev  = RED;
               w_nxt_dwell = c_ONE;
               w_nxt_phase = PH_RED;
               w_nxt_state = ST_TRACK;
            end
`else
            w_nxt_state = ST_FAULT;
`endif
         end
         default: w_nxt_state = ST_SYNC;
      endcase
   end

   assign phase     = r_phase;
   assign in_sync   = (r_state == ST_TRACK);
   assign fault     = (r_state == ST_FAULT);
   assign err_code  = r_err_code;
   assign err_seq   = r_err_seq;
   assign err_dwell = r_err_dwell;
   assign cycles    = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_traffic_light_monitor: directed vector bench for the light monitor |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_traffic_light_monitor;
   import traffic_light_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] light_a = 3'b000, light_b = 3'b000, light_c = 3'b000;

   logic [1:0] ph_a, ph_b, ph_c;
   logic       sy_a, ec_a, es_a, ed_a, ft_a;
   logic       sy_b, ec_b, es_b, ed_b, ft_b;
   logic       sy_c, ec_c, es_c, ed_c, ft_c;
   logic [7:0] cy_a, cy_b;
   logic [1:0] cy_c;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   traffic_light_monitor dut_a (
      .clock(clock), .reset(reset), .light(light_a), .phase(ph_a), .in_sync(sy_a),
      .err_code(ec_a), .err_seq(es_a), .err_dwell(ed_a), .fault(ft_a), .cycles(cy_a));

   traffic_light_monitor #(.MIN_DWELL(3), .MAX_DWELL(3)) dut_b (
      .clock(clock), .reset(reset), .light(light_b), .phase(ph_b), .in_sync(sy_b),
      .err_code(ec_b), .err_seq(es_b), .err_dwell(ed_b), .fault(ft_b), .cycles(cy_b));

   traffic_light_monitor #(.CNT_W(2)) dut_c (
      .clock(clock), .reset(reset), .light(light_c), .phase(ph_c), .in_sync(sy_c),
      .err_code(ec_c), .err_seq(es_c), .err_dwell(ed_c), .fault(ft_c), .cycles(cy_c));

   typedef struct {
      logic       rst;
      logic [2:0] lt;
      logic [1:0] ph;
      logic       sy, ec, es, ed, ft;
      logic [7:0] cy;
   } vec_t;

   vec_t vq[$];

   task automatic addv(input logic rst, input logic [2:0] lt, input logic [1:0] ph,
                       input logic sy, input logic ec, input logic es, input logic ed,
                       input logic ft, input logic [7:0] cy);
      vec_t v;
      v.rst = rst; v.lt = lt; v.ph = ph; v.sy = sy; v.ec = ec;
      v.es = es; v.ed = ed; v.ft = ft; v.cy = cy;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // rst light phase sync ec es ed fault cycles
      addv(1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addv(0, RED,    1, 1, 0, 0, 0, 0, 0);
      addv(0, GREEN,  2, 1, 0, 0, 0, 0, 0);
      addv(0, YELLOW, 3, 1, 0, 0, 0, 0, 0);
      addv(0, RED,    1, 1, 0, 0, 0, 0, 1);
      addv(0, GREEN,  2, 1, 0, 0, 0, 0, 1);
      addv(0, YELLOW, 3, 1, 0, 0, 0, 0, 1);
      addv(0, RED,    1, 1, 0, 0, 0, 0, 2);
      addv(0, RED,    1, 0, 0, 0, 1, 1, 2);   // held too long
      addv(0, GREEN,  1, 0, 0, 0, 0, 1, 2);   // no repeat pulse in FAULT
      addv(1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addv(0, RED,    1, 1, 0, 0, 0, 0, 0);
      addv(0, YELLOW, 1, 0, 0, 1, 0, 1, 0);   // wrong successor
      addv(0, GREEN,  1, 0, 0, 0, 0, 1, 0);
      addv(1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addv(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);   // illegal codes ignored in SYNC
      addv(0, 3'b110, 0, 0, 0, 0, 0, 0, 0);
      addv(0, RED,    1, 1, 0, 0, 0, 0, 0);
      addv(0, GREEN,  2, 1, 0, 0, 0, 0, 0);
      addv(0, 3'b110, 2, 0, 1, 0, 0, 1, 0);   // illegal code while tracking
      addv(1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addv(0, RED,    1, 1, 0, 0, 0, 0, 0);
      addv(0, GREEN,  2, 1, 0, 0, 0, 0, 0);
      addv(0, YELLOW, 3, 1, 0, 0, 0, 0, 0);
      addv(0, RED,    1, 1, 0, 0, 0, 0, 1);
      addv(1, GREEN,  0, 0, 0, 0, 0, 0, 0);   // mid-track reset
      addv(0, RED,    1, 1, 0, 0, 0, 0, 0);

      foreach (vq[i]) begin
         reset   = vq[i].rst;
         light_a = vq[i].lt;
         tick();
         chk($sformatf("v%0d phase", i),     ph_a, vq[i].ph);
         chk($sformatf("v%0d in_sync", i),   sy_a, vq[i].sy);
         chk($sformatf("v%0d err_code", i),  ec_a, vq[i].ec);
         chk($sformatf("v%0d err_seq", i),   es_a, vq[i].es);
         chk($sformatf("v%0d err_dwell", i), ed_a, vq[i].ed);
         chk($sformatf("v%0d fault", i),     ft_a, vq[i].ft);
         chk($sformatf("v%0d cycles", i),    cy_a, vq[i].cy);
      end

      // MIN=MAX=3: exact dwell accepted, fourth hold and short hold rejected
      reset = 1'b1; tick(); reset = 1'b0;
      light_b = RED; tick(); tick(); tick();
      chk("b3 red held ok", {sy_b, ed_b, ft_b}, 3'b100);
      light_b = GREEN; tick();
      chk("b3 green accepted", {ph_b, sy_b, ed_b}, {2'd2, 1'b1, 1'b0});
      tick(); tick();
      chk("b3 green at max", {sy_b, ed_b}, 2'b10);
      tick();
      chk("b3 green too long", {sy_b, ed_b, ft_b}, 3'b011);
      reset = 1'b1; tick(); reset = 1'b0;
      light_b = RED; tick(); tick();
      chk("b3 red x2 no err", {sy_b, ed_b, ft_b}, 3'b100);
      light_b = GREEN; tick();
      chk("b3 too short", {sy_b, ed_b, ft_b, ph_b}, {3'b011, 2'd1});
      tick();
      chk("b3 single pulse", {ed_b, ft_b}, 2'b01);

      // CNT_W=2 saturation, then a sequence fault and optional recovery
      reset = 1'b1; light_b = 3'b000; tick(); reset = 1'b0;
      light_c = RED; tick();
      for (int k = 1; k <= 5; k++) begin
         light_c = GREEN;  tick();
         light_c = YELLOW; tick();
         light_c = RED;    tick();
         chk($sformatf("c cycles after %0d", k), cy_c, (k > 3) ? 3 : k);
      end
      chk("c no errors", {ec_c, es_c, ed_c, ft_c}, 4'b0000);
      light_c = YELLOW; tick();
      chk("c err_seq", {es_c, ft_c, sy_c, ph_c}, {3'b110, 2'd1});
      light_c = RED; tick();
`ifdef TRAFFIC_LIGHT_MONITOR_RECOVER_EN
      chk("c recover", {ft_c, sy_c, ph_c, cy_c}, {2'b01, 2'd1, 2'd3});
      light_c = GREEN; tick();
      chk("c track after recover", {ft_c, sy_c, ph_c, es_c}, {2'b01, 2'd2, 1'b0});
`else
      chk("c fault absorbing", {ft_c, sy_c, ph_c, cy_c}, {2'b10, 2'd1, 2'd3});
      light_c = GREEN; tick();
      chk("c still fault", {ft_c, sy_c, es_c, ed_c}, 4'b1000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
